// File: rtl/ca_code_gen_multi.sv
// ca_code_gen_multi: multi-channel GPS L1 C/A Gold-code generator with runtime taps and code-phase slew
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   chip_en             one-clock strobe advancing every enabled, non-slewing channel by one chip
//   ch_en               per-channel run enable
//   cfg_we, cfg_ch      configuration write strobe and target channel
//   cfg_t0, cfg_t1      G2 phase-selector taps (1..10, anything else contributes 0)
//   cfg_phase           start code phase in chips, clamped to 1022
//   cfg_ready           high while a write can be accepted
//   code, epoch         per-channel replica chip and 1022->0 wrap pulse
//   chip_idx            per-channel chip index, channel 0 in the LSBs
//   ms_cnt, bit_edge    per-channel epoch counter (mod 20) and its wrap pulse; built only when
//                       CA_MS_COUNTER_EN is defined, otherwise tied to 0
module ca_code_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int DEF_T0 = 2,
  parameter int DEF_T1 = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chip_en,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [3:0]           cfg_t0,
  input  logic [3:0]           cfg_t1,
  input  logic [9:0]           cfg_phase,
  output logic                 cfg_ready,
  output logic [NUM_CH-1:0]    code,
  output logic [NUM_CH-1:0]    epoch,
  output logic [NUM_CH*10-1:0] chip_idx,
  output logic [NUM_CH*5-1:0]  ms_cnt,
  output logic [NUM_CH-1:0]    bit_edge
);
  typedef enum logic {IDLE, SLEW} state_t;
  state_t state, nxt;
  logic [CH_W-1:0] tgt;
  logic [9:0] cnt;
  logic accept;
  // Stage n lives in bit n-1, so stage 10 (the output) is bit 9.
  function automatic logic [9:0] g1_step(input logic [9:0] g);
    return {g[8:0], g[2] ^ g[9]};
  endfunction
  function automatic logic [9:0] g2_step(input logic [9:0] g);
    return {g[8:0], g[1] ^ g[2] ^ g[5] ^ g[7] ^ g[8] ^ g[9]};
  endfunction
  // Zero-padding on both sides makes taps 0 and 11..15 read as 0 without a range check.
  function automatic logic tap(input logic [9:0] g, input logic [3:0] t);
    logic [15:0] e;
    e = {5'b0, g, 1'b0};
    return e[t];
  endfunction
  assign accept = state == IDLE && cfg_we && 32'(cfg_ch) < NUM_CH;
  assign cfg_ready = state == IDLE;
  always_comb nxt = accept ? SLEW : (state == SLEW && cnt == '0) ? IDLE : state;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tgt <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        tgt <= cfg_ch;
        cnt <= cfg_phase > 10'd1022 ? 10'd1022 : cfg_phase;
      end else if (state == SLEW && cnt != '0) cnt <= cnt - 10'd1;
    end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [9:0] g1, g2, idx;
    logic [3:0] t0, t1;
    logic ep, load, slewing, adv, wrap, step;
    assign load = accept && cfg_ch == CH_W'(c);
    assign slewing = state == SLEW && tgt == CH_W'(c);
    assign adv = chip_en && ch_en[c] && !slewing;
    assign wrap = adv && idx == 10'd1022;
    // The final slew cycle (cnt == 0) only hands control back, so the channel rests at the requested chip.
    assign step = (slewing && cnt != '0) || (adv && !wrap);
    always_ff @(posedge clk)
      if (rst) begin
        g1 <= '1;
        g2 <= '1;
        idx <= '0;
        t0 <= 4'(DEF_T0);
        t1 <= 4'(DEF_T1);
        ep <= 1'b0;
      end else begin
        ep <= wrap && !load;
        if (load || wrap) begin
          g1 <= '1;
          g2 <= '1;
          idx <= '0;
        end else if (step) begin
          g1 <= g1_step(g1);
          g2 <= g2_step(g2);
          idx <= idx + 10'd1;
        end
        if (load) begin
          t0 <= cfg_t0;
          t1 <= cfg_t1;
        end
      end
    assign code[c] = g1[9] ^ tap(g2, t0) ^ tap(g2, t1);
    assign epoch[c] = ep;
    assign chip_idx[c*10 +: 10] = idx;
`ifdef CA_MS_COUNTER_EN
    logic [4:0] ms;
    logic be;
    always_ff @(posedge clk)
      if (rst) begin
        ms <= '0;
        be <= 1'b0;
      end else begin
        be <= wrap && !load && ms == 5'd19;
        if (load) ms <= '0;
        else if (wrap) ms <= ms == 5'd19 ? 5'd0 : ms + 5'd1;
      end
    assign ms_cnt[c*5 +: 5] = ms;
    assign bit_edge[c] = be;
`else
    assign ms_cnt[c*5 +: 5] = '0;
    assign bit_edge[c] = 1'b0;
`endif
  end
endmodule
